// File: rtl/pcounter_n.sv
// Programmable up/down counter with wrap, saturate and one-shot boundary modes.
// Optional tick prescaler is built only when PCOUNTER_N_PRESCALER_EN is defined.
module pcounter_n #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      step,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [WIDTH-1:0]      min_count,
  input  logic [WIDTH-1:0]      max_count,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  done,
  output logic                  zero,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_done;

  mode_e            w_mode;
  logic             w_expired;
  logic             w_tick;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_down_floor;
  logic             w_up_fits;
  logic             w_down_fits;
  logic [WIDTH-1:0] w_count_nx;
  logic             w_tc_nx;
  logic             w_done_nx;

  assign w_mode  = mode_e'(mode);
  assign cfg_err = (min_count > max_count);
  assign zero    = (r_count == '0);
  assign count   = r_count;
  assign tc      = r_tc;
  assign done    = r_done;

`ifdef PCOUNTER_N_PRESCALER_EN
  logic [PRESCALE_W-1:0] r_pre;

  assign w_expired = (r_pre == prescale);

  // The divider runs on enable alone, so done/cfg_err do not disturb its phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (load) begin
      r_pre <= '0;
    end else if (enable) begin
      r_pre <= w_expired ? '0 : r_pre + 1'b1;
    end
  end
`else
  logic w_unused_prescale;

  assign w_expired         = 1'b1;
  assign w_unused_prescale = ^prescale;
`endif

  assign w_tick       = enable && !r_done && !cfg_err && w_expired;
  // Both comparisons are done one bit wider so count+step cannot overflow.
  assign w_sum        = {1'b0, r_count} + {1'b0, step};
  assign w_down_floor = {1'b0, min_count} + {1'b0, step};
  assign w_up_fits    = (w_sum <= {1'b0, max_count});
  assign w_down_fits  = ({1'b0, r_count} >= w_down_floor);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_count_nx = r_count;
    w_tc_nx    = 1'b0;
    w_done_nx  = r_done;

    if (load) begin
      w_count_nx = load_value;
      w_done_nx  = 1'b0;
    end else if (w_tick) begin
      if (up_down) begin
        if (w_up_fits) begin
          w_count_nx = w_sum[WIDTH-1:0];
        end else begin
          w_tc_nx = 1'b1;
          unique case (w_mode)
            MODE_SAT:     w_count_nx = max_count;
            MODE_ONESHOT: begin
              w_count_nx = max_count;
              w_done_nx  = 1'b1;
            end
            default:      w_count_nx = min_count;
          endcase
        end
      end else begin
        if (w_down_fits) begin
          w_count_nx = r_count - step;
        end else begin
          w_tc_nx = 1'b1;
          unique case (w_mode)
            MODE_SAT:     w_count_nx = min_count;
            MODE_ONESHOT: begin
              w_count_nx = min_count;
              w_done_nx  = 1'b1;
            end
            default:      w_count_nx = max_count;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_nx;
      r_tc    <= w_tc_nx;
      r_done  <= w_done_nx;
    end
  end

endmodule

// File: tb/tb_pcounter_n.sv
// Self-checking bench for pcounter_n: directed scenarios plus random traffic,
// scored against an arithmetic reference model through an expectation queue.
module tb_pcounter_n;

  localparam int W  = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic          enable;
  logic          up_down;
  logic [1:0]    mode;
  logic [W-1:0]  step;
  logic [W-1:0]  load_value;
  logic [W-1:0]  min_count;
  logic [W-1:0]  max_count;
  logic [PW-1:0] prescale;
  logic [W-1:0]  count;
  logic          tc;
  logic          done;
  logic          zero;
  logic          cfg_err;

  pcounter_n #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .enable     (enable),
    .up_down    (up_down),
    .mode       (mode),
    .step       (step),
    .load_value (load_value),
    .min_count  (min_count),
    .max_count  (max_count),
    .prescale   (prescale),
    .count      (count),
    .tc         (tc),
    .done       (done),
    .zero       (zero),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    bit tc;
    bit done;
    bit zero;
    bit cfg_err;
  } exp_t;

  exp_t exp_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  int m_count = 0;
  int m_pre   = 0;
  bit m_done  = 0;
  bit m_tc    = 0;

  int seq_wrap[6] = '{6, 7, 8, 9, 10, 0};

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour for one rising edge, from the counting rules directly.
  task automatic model_cycle();
    bit tick;
    bit boundary;
    int lo;
    int hi;
    lo = int'(min_count);
    hi = int'(max_count);
    if (rst) begin
      m_count = 0; m_pre = 0; m_done = 0; m_tc = 0;
    end else if (load) begin
      m_count = int'(load_value); m_pre = 0; m_done = 0; m_tc = 0;
    end else begin
`ifdef PCOUNTER_N_PRESCALER_EN
      tick = enable && !m_done && (lo <= hi) && (m_pre == int'(prescale));
      if (enable) m_pre = (m_pre == int'(prescale)) ? 0 : (m_pre + 1) % (1 << PW);
`else
      tick = enable && !m_done && (lo <= hi);
`endif
      m_tc = 0;
      if (tick) begin
        boundary = 0;
        if (up_down) begin
          if (m_count + int'(step) <= hi) m_count = m_count + int'(step);
          else boundary = 1;
        end else begin
          if (m_count >= lo + int'(step)) m_count = m_count - int'(step);
          else boundary = 1;
        end
        if (boundary) begin
          m_tc = 1;
          if (mode == 2'b01 || mode == 2'b10) m_count = up_down ? hi : lo;
          else m_count = up_down ? lo : hi;
          if (mode == 2'b10) m_done = 1;
        end
      end
    end
  endtask

  // Predict the coming edge, queue the expectation, then return at the next falling edge.
  task automatic clk_cycle();
    exp_t e;
    model_cycle();
    e.count   = m_count;
    e.tc      = m_tc;
    e.done    = m_done;
    e.zero    = (m_count == 0);
    e.cfg_err = (min_count > max_count);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic expect_now(input string name, input int exp_count, input bit exp_tc);
    check({name, ".count"}, 32'(count), 32'(exp_count));
    check({name, ".tc"}, 32'(tc), 32'(exp_tc));
  endtask

  task automatic set_cfg(input logic [1:0] md, input logic up, input int stp,
                         input int lo, input int hi, input int pre);
    mode      = md;
    up_down   = up;
    step      = W'(stp);
    min_count = W'(lo);
    max_count = W'(hi);
    prescale  = PW'(pre);
  endtask

  task automatic do_load(input int v);
    load       = 1'b1;
    load_value = W'(v);
    clk_cycle();
    load       = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb.count", 32'(count), 32'(e.count));
        check("sb.tc", 32'(tc), 32'(e.tc));
        check("sb.done", 32'(done), 32'(e.done));
        check("sb.zero", 32'(zero), 32'(e.zero));
        check("sb.cfg_err", 32'(cfg_err), 32'(e.cfg_err));
      end
    end
  end

  initial begin : driver
    rst = 1'b1; load = 1'b0; enable = 1'b0; load_value = '0;
    set_cfg(2'b00, 1'b1, 1, 0, 10, 0);
    @(negedge clk);
    clk_cycle();
    clk_cycle();
    check("reset.count", 32'(count), 32'd0);
    check("reset.zero", 32'(zero), 32'd1);
    check("reset.tc", 32'(tc), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    rst = 1'b0;

    // Wrap up from 5 through the top bound.
    do_load(5);
    expect_now("wrap.load", 5, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clk_cycle();
      expect_now("wrap.seq", seq_wrap[i], (i == 5));
    end

    // Saturating down-count, pinned at the lower bound.
    enable = 1'b0;
    set_cfg(2'b01, 1'b0, 3, 2, 20, 0);
    do_load(7);
    enable = 1'b1;
    clk_cycle(); expect_now("sat.t1", 4, 1'b0);
    clk_cycle(); expect_now("sat.t2", 2, 1'b1);
    clk_cycle(); expect_now("sat.t3", 2, 1'b1);
    enable = 1'b0;
    clk_cycle(); expect_now("sat.hold", 2, 1'b0);

    // One-shot up, then reload clears done.
    set_cfg(2'b10, 1'b1, 4, 0, 10, 0);
    do_load(0);
    enable = 1'b1;
    clk_cycle(); expect_now("os.t1", 4, 1'b0);
    clk_cycle(); expect_now("os.t2", 8, 1'b0);
    clk_cycle(); expect_now("os.t3", 10, 1'b1);
    check("os.done", 32'(done), 32'd1);
    clk_cycle(); expect_now("os.after1", 10, 1'b0);
    clk_cycle(); expect_now("os.after2", 10, 1'b0);
    do_load(3);
    expect_now("os.reload", 3, 1'b0);
    check("os.done_clr", 32'(done), 32'd0);

    // Prescaler division and restart on load.
    set_cfg(2'b00, 1'b1, 1, 0, 200, 2);
    enable = 1'b0;
    do_load(0);
    enable = 1'b1;
`ifdef PCOUNTER_N_PRESCALER_EN
    clk_cycle(); expect_now("pre.c1", 0, 1'b0);
    clk_cycle(); expect_now("pre.c2", 0, 1'b0);
    clk_cycle(); expect_now("pre.c3", 1, 1'b0);
    clk_cycle(); expect_now("pre.c4", 1, 1'b0);
    do_load(10);
    clk_cycle(); expect_now("pre.r1", 10, 1'b0);
    clk_cycle(); expect_now("pre.r2", 10, 1'b0);
    clk_cycle(); expect_now("pre.r3", 11, 1'b0);
`else
    clk_cycle(); expect_now("nopre.c1", 1, 1'b0);
    clk_cycle(); expect_now("nopre.c2", 2, 1'b0);
    clk_cycle(); expect_now("nopre.c3", 3, 1'b0);
`endif

    // Inverted bounds freeze the count but not a load.
    enable = 1'b0;
    set_cfg(2'b00, 1'b1, 1, 0, 50, 0);
    do_load(3);
    set_cfg(2'b00, 1'b1, 1, 9, 4, 0);
    enable = 1'b1;
    #1 check("cfg.err", 32'(cfg_err), 32'd1);
    clk_cycle(); expect_now("cfg.frozen1", 3, 1'b0);
    clk_cycle(); expect_now("cfg.frozen2", 3, 1'b0);
    do_load(7);
    expect_now("cfg.load", 7, 1'b0);

    // Asynchronous reset between edges, then load beats enable.
    enable = 1'b0;
    set_cfg(2'b00, 1'b1, 1, 0, 100, 0);
    do_load(6);
    expect_now("arst.pre", 6, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst.count", 32'(count), 32'd0);
    check("arst.zero", 32'(zero), 32'd1);
    m_count = 0; m_pre = 0; m_done = 0; m_tc = 0;
    @(negedge clk);
    clk_cycle();
    rst    = 1'b0;
    enable = 1'b1;
    do_load(9);
    expect_now("ld_vs_en", 9, 1'b0);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      load    = ($urandom_range(0, 15) == 0);
      enable  = ($urandom_range(0, 3) != 0);
      up_down = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) step = W'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) begin
        min_count = W'($urandom_range(0, 40));
        max_count = W'($urandom_range(30, 255));
      end
      if ($urandom_range(0, 31) == 0) prescale = PW'($urandom_range(0, 3));
      load_value = W'($urandom_range(0, 255));
      clk_cycle();
    end
    rst = 1'b0; load = 1'b0; enable = 1'b0;

    @(posedge clk);
    #3;
    check("sb.drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/pcounter_n.md
PCOUNTER_N -- requirements
Module: pcounter_n

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the count/bound/step width (min 2).
REQ-002 SHALL have parameter PRESCALE_W, default 8, meaning the prescaler divide-value width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port load  input  1  meaning a synchronous load of load_value.
REQ-006 SHALL have port enable  input  1  meaning a count enable.
REQ-007 SHALL have port up_down  input  1  meaning direction: 1 = up, 0 = down.
REQ-008 SHALL have port mode  input  2  meaning 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-009 SHALL have port step  input  WIDTH  meaning the increment/decrement per tick (0 = hold).
REQ-010 SHALL have port load_value  input  WIDTH  meaning the value loaded on load.
REQ-011 SHALL have port min_count  input  WIDTH  meaning the lower bound, inclusive.
REQ-012 SHALL have port max_count  input  WIDTH  meaning the upper bound, inclusive.
REQ-013 SHALL have port prescale  input  PRESCALE_W  meaning the tick divide value; one tick per prescale+1 enabled cycles.
REQ-014 SHALL have port count  output  WIDTH  meaning the registered count.
REQ-015 SHALL have port tc  output  1  meaning a registered one-cycle boundary-event pulse.
REQ-016 SHALL have port zero  output  1  meaning combinational (count == 0).
REQ-017 SHALL have port done  output  1  meaning registered: one-shot finished.
REQ-018 SHALL have port cfg_err  output  1  meaning combinational (min_count > max_count).

Function
REQ-019 Priority SHALL be: rst > load > tick > hold.
REQ-020 load SHALL set count = load_value unclamped, clear done, clear tc and reset the prescaler, all in one cycle.
REQ-021 tick SHALL equal enable && !done && !cfg_err && prescaler expired; prescaler counts only while enable=1 and holds otherwise.
REQ-022 Up tick: the block SHALL compute count+step in WIDTH+1 bits; if the result <= max_count, then count = result, otherwise a boundary event occurs.
REQ-023 Down tick: if count >= min_count+step (computed in WIDTH+1 bits), the block SHALL set count = count-step, otherwise a boundary event occurs.
REQ-024 Up boundary event SHALL give: wrap -> count = min_count; saturate -> count = max_count; one-shot -> count = max_count and done = 1.
REQ-025 Down boundary event SHALL give: wrap -> count = max_count; saturate -> count = min_count; one-shot -> count = min_count and done = 1.
REQ-026 tc SHALL be 1 for exactly the cycle after each boundary event (aligned with the count update) and 0 otherwise; saturate SHALL re-pulse on every blocked tick.
REQ-027 A direction, mode or bound change SHALL take effect on the next tick, with no flush.
REQ-028 With cfg_err=1, count SHALL hold, except that load is still honoured.
REQ-029 With done=1, ticks SHALL be ignored until load or rst.

Reset
REQ-030 rst SHALL asynchronously force count = 0, tc = 0, done = 0 and prescaler = 0; the zero output is then 1.
REQ-031 rst asserted mid-count or mid-prescale SHALL discard all state; counting SHALL resume on the first edge after rst deasserts.

Configuration
REQ-032 When macro PCOUNTER_N_PRESCALER_EN is defined, the prescaler SHALL be built per REQ-013/REQ-021.
REQ-033 When PCOUNTER_N_PRESCALER_EN is undefined, the prescaler SHALL be removed, the prescale input ignored, and tick = enable && !done && !cfg_err.

Verification
REQ-034 The bench SHALL check: WIDTH=8, min=0, max=10, load 5, up, step 1, wrap, prescale 0 -> 6,7,8,9,10,0 with tc pulse at 0.
REQ-035 The bench SHALL check: saturate, down, step 3, from 7, min 2 -> 4, 2, 2, with tc on each blocked tick; enable low for one cycle -> count holds.
REQ-036 The bench SHALL check: one-shot, up, step 4, 0 to max 10 -> 4, 8, 10, done=1, then further ticks hold 10; load 3 -> count 3, done 0.
REQ-037 The bench SHALL check: macro defined, prescale 2, enable held -> count advances every 3rd cycle; load mid-prescale restarts the division.
REQ-038 The bench SHALL check: min=9, max=4 -> cfg_err=1 and count frozen; load 7 -> count 7.
REQ-039 The bench SHALL check: rst pulsed between clock edges at count 6 -> count 0 and zero=1 immediately; load+enable in the same cycle -> load wins.
